// File: rtl/bcd_disp_mux_pkg.sv
// ---------------------------------------------------------------------------
// bcd_disp_mux_pkg
// Shared definitions for the stopwatch display path:
//   - active-low 7-segment patterns {g,f,e,d,c,b,a} for 0..9, dash and off
//   - scan slot codes (which digit is being driven)
//   - counter run/idle encoding, shared with the BCD counter
// ---------------------------------------------------------------------------
package bcd_disp_mux_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {
        SLOT_ONES     = 2'd0,
        SLOT_TENS     = 2'd1,
        SLOT_HUNDREDS = 2'd2
    } slot_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cnt_state_e;

endpackage

// File: rtl/bcd_disp_mux_bcd_to_7seg.sv
// ---------------------------------------------------------------------------
// bcd_to_7seg
// Combinational BCD to active-low 7-segment decoder. Non-BCD codes (10..15)
// show a dash so a corrupted counter value is visible rather than silent.
//   bcd : 4-bit digit in
//   seg : {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module bcd_to_7seg
    import bcd_disp_mux_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_disp_mux.sv
// ---------------------------------------------------------------------------
// bcd_disp_mux
// Time-multiplexes the three stopwatch digits onto one common-anode
// 7-segment bus. Digits and run state are snapshotted once per scan frame
// so a count update never tears across slots. Optional leading-zero
// blanking, a fixed decimal point and blink-while-idle.
//
// Ports
//   clk      : system clock, rising edge
//   ar       : asynchronous reset, active-low
//   dig1..3  : BCD ones / tens / hundreds from the counter
//   state    : counter state, 0 = IDLE, 1 = RUN
//   blank_lz : 1 = suppress leading zeros (used live, not snapshotted)
//   seg      : segments {g,f,e,d,c,b,a}, active-low, registered
//   an       : digit enables {dig3,dig2,dig1}, active-low one-hot, registered
//   dp       : decimal point, active-low, registered
//   frame    : one-cycle pulse, first cycle of each new frame
// ---------------------------------------------------------------------------
module bcd_disp_mux
    import bcd_disp_mux_pkg::*;
#(
    parameter int PRESCALE     = 1000,  // clk cycles per digit slot, 1..65535
    parameter int BLINK_FRAMES = 64,    // blink period in frames, even, >= 2
    parameter int DP_POS       = 1      // 0/1/2 = slot with dp lit, 3 = none
) (
    input  logic       clk,
    input  logic       ar,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic       state,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       dp,
    output logic       frame
);

    localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);
    localparam int          BW     = $clog2(BLINK_FRAMES);
    localparam logic [BW-1:0] B_MAX  = BW'(BLINK_FRAMES - 1);
    localparam logic [BW-1:0] B_HALF = BW'(BLINK_FRAMES / 2);
    localparam logic [1:0]  DP_SLOT = 2'(DP_POS);

    logic [15:0]     pcnt;
    slot_e           idx;
    logic [BW-1:0]   bcnt;
    logic [3:0]      snap1, snap2, snap3;
    cnt_state_e      snap_st;

    logic            tick;
    logic            frame_tick;
    logic [3:0]      cur_dig;
    logic [6:0]      cur_seg;
    logic            blank;
    logic            dark;
    logic [2:0]      an_nxt;

    assign tick       = (pcnt == PS_MAX);
    assign frame_tick = tick && (idx == SLOT_HUNDREDS);

    // Prescaler and scan index
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            pcnt <= '0;
            idx  <= SLOT_ONES;
        end else if (tick) begin
            pcnt <= '0;
            case (idx)
                SLOT_ONES: idx <= SLOT_TENS;
                SLOT_TENS: idx <= SLOT_HUNDREDS;
                default:   idx <= SLOT_ONES;
            endcase
        end else begin
            pcnt <= pcnt + 16'd1;
        end
    end

    // Frame snapshot and blink counter. The counter is forced to 0 while the
    // outgoing or incoming frame is RUN, so the first idle frame after RUN
    // starts at 0 and always opens with a lit half-period.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            snap1   <= '0;
            snap2   <= '0;
            snap3   <= '0;
            snap_st <= ST_IDLE;
            bcnt    <= '0;
        end else if (frame_tick) begin
            snap1   <= dig1;
            snap2   <= dig2;
            snap3   <= dig3;
            snap_st <= cnt_state_e'(state);
            if (snap_st == ST_RUN || cnt_state_e'(state) == ST_RUN)
                bcnt <= '0;
            else if (bcnt == B_MAX)
                bcnt <= '0;
            else
                bcnt <= bcnt + 1'b1;
        end
    end

    // Digit select from the snapshot, then a single shared decoder
    always_comb begin
        cur_dig = snap1;
        an_nxt  = 3'b110;
        case (idx)
            SLOT_ONES:     begin cur_dig = snap1; an_nxt = 3'b110; end
            SLOT_TENS:     begin cur_dig = snap2; an_nxt = 3'b101; end
            SLOT_HUNDREDS: begin cur_dig = snap3; an_nxt = 3'b011; end
            default:       begin cur_dig = snap1; an_nxt = 3'b111; end
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd (cur_dig),
        .seg (cur_seg)
    );

    always_comb begin
        blank = 1'b0;
        if (blank_lz) begin
            if (idx == SLOT_HUNDREDS && snap3 == 4'd0)
                blank = 1'b1;
            else if (idx == SLOT_TENS && snap3 == 4'd0 && snap2 == 4'd0)
                blank = 1'b1;
        end
    end

    assign dark = (snap_st == ST_IDLE) && (bcnt >= B_HALF);

    // Registered outputs. In the tick cycle all anodes go dark for one
    // cycle so the old segment pattern never ghosts onto the next digit.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            seg   <= SEG_OFF;
            an    <= 3'b111;
            dp    <= 1'b1;
            frame <= 1'b0;
        end else begin
            frame <= frame_tick;
            an    <= tick ? 3'b111 : an_nxt;
            seg   <= (dark || blank) ? SEG_OFF : cur_seg;
            dp    <= !((2'(idx) == DP_SLOT) && !dark);
        end
    end

endmodule

// File: tb/tb_bcd_disp_mux.sv
// ---------------------------------------------------------------------------
// tb_bcd_disp_mux
// Directed + randomized bench. Inputs are logged per cycle; the expected
// display is rebuilt from the cycle number (slot position inside the frame),
// the inputs logged at the frame boundaries, and the length of the current
// idle run for blinking.
// ---------------------------------------------------------------------------
module tb_bcd_disp_mux;

    localparam int PS  = 4;
    localparam int BF  = 4;
    localparam int DPP = 1;
    localparam int FR  = PS * 3;
    localparam int HN  = 4096;

    logic       clk = 1'b0;
    logic       ar  = 1'b0;
    logic [3:0] dig1 = 4'd0, dig2 = 4'd0, dig3 = 4'd0;
    logic       state = 1'b0, blank_lz = 1'b0;
    logic [6:0] seg;
    logic [2:0] an;
    logic       dp, frame;

    int n_assert = 0;
    int n_fail   = 0;
    int t        = 0;

    logic [3:0] h1 [0:HN-1];
    logic [3:0] h2 [0:HN-1];
    logic [3:0] h3 [0:HN-1];
    logic       hst[0:HN-1];
    logic       hbz[0:HN-1];
    logic [6:0] segtab [0:9];

    always #5 clk = ~clk;

    bcd_disp_mux #(.PRESCALE(PS), .BLINK_FRAMES(BF), .DP_POS(DPP)) dut (
        .clk      (clk),
        .ar       (ar),
        .dig1     (dig1),
        .dig2     (dig2),
        .dig3     (dig3),
        .state    (state),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .dp       (dp),
        .frame    (frame)
    );

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [6:0] ref_dec(input logic [3:0] d);
        if (d > 4'd9) return 7'h3F;
        return segtab[d];
    endfunction

    // Snapshotted run state of frame g (frame 0 = before first boundary)
    function automatic logic snap_st(input int g);
        if (g == 0) return 1'b0;
        return hst[FR * g - 1];
    endfunction

    // Expected outputs right after rising edge k (k >= 1 since release)
    task automatic check_cycle(input int k);
        int pre, c, s, f, r;
        logic [3:0] d1, d2, d3, dsel;
        logic st, dark, blank;
        logic [2:0] ean;
        logic [6:0] eseg;
        logic edp;
        pre = k - 1;
        c   = pre % PS;
        s   = (pre / PS) % 3;
        f   = pre / FR;
        if (f == 0) begin
            d1 = 4'd0; d2 = 4'd0; d3 = 4'd0;
        end else begin
            d1 = h1[FR*f-1]; d2 = h2[FR*f-1]; d3 = h3[FR*f-1];
        end
        st = snap_st(f);
        r  = 0;
        for (int g = f; g >= 0; g--) begin
            if (snap_st(g)) break;
            r++;
        end
        dark  = !st && (((r - 1) % BF) >= BF / 2);
        dsel  = (s == 0) ? d1 : (s == 1) ? d2 : d3;
        blank = hbz[pre] && ((s == 2 && d3 == 0) || (s == 1 && d3 == 0 && d2 == 0));
        ean   = (c == PS - 1) ? 3'b111 : ~(3'b001 << s);
        eseg  = (dark || blank) ? 7'h7F : ref_dec(dsel);
        edp   = !(s == DPP && !dark);
        chk("an", 7'(an), 7'(ean));
        chk("frame", 7'(frame), 7'((k % FR) == 0));
        if (c != PS - 1) begin
            chk("seg", seg, eseg);
            chk("dp", 7'(dp), 7'(edp));
        end
    endtask

    task automatic cyc();
        h1[t] = dig1; h2[t] = dig2; h3[t] = dig3;
        hst[t] = state; hbz[t] = blank_lz;
        @(posedge clk);
        t++;
        @(negedge clk);
        check_cycle(t);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic set_digs(input logic [3:0] a3, input logic [3:0] a2, input logic [3:0] a1);
        dig3 = a3; dig2 = a2; dig1 = a1;
    endtask

    initial begin
        segtab[0] = 7'h40; segtab[1] = 7'h79; segtab[2] = 7'h24; segtab[3] = 7'h30;
        segtab[4] = 7'h19; segtab[5] = 7'h12; segtab[6] = 7'h02; segtab[7] = 7'h78;
        segtab[8] = 7'h00; segtab[9] = 7'h10;

        // Reset held with clock running
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", 7'(an), 7'h07);
        chk("rst_dp", 7'(dp), 7'h01);
        chk("rst_frame", 7'(frame), 7'h00);

        // Scan: RUN, digits 3/2/1, no blanking
        state = 1'b1; blank_lz = 1'b0;
        set_digs(4'd3, 4'd2, 4'd1);
        ar = 1'b1; t = 0;
        run(3 * FR);

        // Coherence: change mid-frame, display holds until next boundary
        set_digs(4'd1, 4'd2, 4'd3);
        run(FR);
        run(5);
        set_digs(4'd4, 4'd5, 4'd6);
        run(2 * FR - 5);

        // Leading-zero blanking
        blank_lz = 1'b1;
        set_digs(4'd0, 4'd0, 4'd7);
        run(2 * FR);
        set_digs(4'd0, 4'd5, 4'd0);
        run(2 * FR);
        blank_lz = 1'b0;

        // Blink while idle, then back to RUN
        set_digs(4'd9, 4'd8, 4'd7);
        state = 1'b0;
        run(10 * FR);
        state = 1'b1;
        run(3 * FR);

        // Invalid BCD shows dash
        set_digs(4'd2, 4'd4, 4'hB);
        run(2 * FR);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) dig1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) dig2 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) dig3 = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) state = ~state;
            if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
            cyc();
        end

        // Reset mid-slot, away from any clock edge
        #2 ar = 1'b0;
        #1;
        chk("mid_rst_seg", seg, 7'h7F);
        chk("mid_rst_an", 7'(an), 7'h07);
        chk("mid_rst_dp", 7'(dp), 7'h01);
        chk("mid_rst_frame", 7'(frame), 7'h00);
        @(negedge clk);
        ar = 1'b1; t = 0;
        state = 1'b1; blank_lz = 1'b1;
        set_digs(4'd0, 4'd0, 4'd5);
        run(3 * FR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
